fb_fill_ctrl: RTL and testbench

Bus-mapped rectangle-fill engine and write arbiter for the 160x120 one-bit frame buffer's write port (port A). The processor programs a rectangle and colour through a small register window, then starts the fill; the block sequences one pixel write per cycle in raster order. It shares port A with a direct single-pixel requester, which always has priority. It sits between the data bus and the frame buffer, alongside the VGA peripheral.

---
 rtl/fb_fill_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fb_fill_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_fill_ctrl.sv
// fb_fill_ctrl: bus-programmed rectangle fill for the 160x120 frame buffer port A.
// Ports: CLK/RESET, BUS_* register window, PIX_* direct writer (priority), FB_* port A, BUSY.
module fb_fill_ctrl #(
  parameter logic [7:0] BaseAddr = 8'hC0,
  parameter logic [7:0] XMAX     = 8'd159,
  parameter logic [7:0] YMAX     = 8'd119
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  inout  wire  [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  input  logic        PIX_REQ,
  input  logic [14:0] PIX_ADDR,
  input  logic        PIX_DATA,
  output logic        PIX_GNT,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_FILL
  } state_t;

  state_t state_q, state_d;

  logic [7:0] x0_q, y0_q;
  logic [7:0] x1_q, y1_q;
  logic       colour_q;
  logic       fill_col_q;
  logic       done_q;
  logic [7:0] xl_q, xh_q;
  logic [7:0] yl_q, yh_q;
  logic [7:0] cx_q, cy_q;
  logic       rd_en_q;
  logic [7:0] rd_q;

  logic       in_win;
  logic [2:0] off;
  logic       wr, rd;
  logic       wr_ctrl;
  logic       start, abort;
  logic       step, last;
  logic       fill_done;
  logic [7:0] rd_mux;
  logic [7:0] xl_d, xh_d;
  logic [7:0] yl_d, yh_d;

  function automatic logic [7:0] clamp(
    input logic [7:0] v,
    input logic [7:0] m
  );
    return (v > m) ? m : v;
  endfunction

  assign in_win = (BUS_ADDR >= BaseAddr) &&
                  (BUS_ADDR <= BaseAddr + 8'd5);
  // window is 6 wide, so the low 3 bits give the offset
  assign off     = BUS_ADDR[2:0] - BaseAddr[2:0];
  assign wr      = in_win & BUS_WE;
  assign rd      = in_win & ~BUS_WE;
  assign wr_ctrl = wr && (off == 3'd4);

  assign BUSY    = (state_q != S_IDLE);
  assign start   = wr_ctrl & BUS_DATA[7] & ~BUSY;
  assign abort   = wr_ctrl & BUS_DATA[6] & BUSY;
  assign step    = (state_q == S_FILL) & ~PIX_REQ;
  assign last    = (cx_q == xh_q) && (cy_q == yh_q);
  assign fill_done = step & last & ~abort;

  always_comb begin
    xl_d = clamp((x0_q < x1_q) ? x0_q : x1_q, XMAX);
    xh_d = clamp((x0_q < x1_q) ? x1_q : x0_q, XMAX);
    yl_d = clamp((y0_q < y1_q) ? y0_q : y1_q, YMAX);
    yh_d = clamp((y0_q < y1_q) ? y1_q : y0_q, YMAX);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: state_d = S_FILL;
      S_FILL:  if (step && last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (off)
      3'd0:    rd_mux = x0_q;
      3'd1:    rd_mux = y0_q;
      3'd2:    rd_mux = x1_q;
      3'd3:    rd_mux = y1_q;
      3'd4:    rd_mux = {7'b0, colour_q};
      3'd5:    rd_mux = {6'b0, done_q, BUSY};
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    FB_WE   = 1'b0;
    FB_ADDR = 15'h0000;
    FB_DATA = 1'b0;
    if (PIX_REQ) begin
      FB_WE   = 1'b1;
      FB_ADDR = PIX_ADDR;
      FB_DATA = PIX_DATA;
    end else if (state_q == S_FILL) begin
      FB_WE   = 1'b1;
      FB_ADDR = {cy_q[6:0], cx_q};
      FB_DATA = fill_col_q;
    end
  end

  assign PIX_GNT  = PIX_REQ;
  assign BUS_DATA = rd_en_q ? rd_q : 8'bz;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      x0_q       <= 8'h00;
      y0_q       <= 8'h00;
      x1_q       <= 8'h00;
      y1_q       <= 8'h00;
      colour_q   <= 1'b0;
      fill_col_q <= 1'b0;
      done_q     <= 1'b0;
      xl_q       <= 8'h00;
      xh_q       <= 8'h00;
      yl_q       <= 8'h00;
      yh_q       <= 8'h00;
      cx_q       <= 8'h00;
      cy_q       <= 8'h00;
      rd_en_q    <= 1'b0;
      rd_q       <= 8'h00;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd;
      rd_q    <= rd_mux;

      if (wr && !BUSY) begin
        case (off)
          3'd0:    x0_q <= BUS_DATA;
          3'd1:    y0_q <= BUS_DATA;
          3'd2:    x1_q <= BUS_DATA;
          3'd3:    y1_q <= BUS_DATA;
          default: ;
        endcase
      end
      if (wr_ctrl) colour_q <= BUS_DATA[0];

      // completion wins over a same-cycle STATUS read so DONE is never lost
      if (start) done_q <= 1'b0;
      else if (fill_done) done_q <= 1'b1;
      else if (rd && off == 3'd5) done_q <= 1'b0;

      unique case (state_q)
        S_SETUP: begin
          xl_q       <= xl_d;
          xh_q       <= xh_d;
          yl_q       <= yl_d;
          yh_q       <= yh_d;
          cx_q       <= xl_d;
          cy_q       <= yl_d;
          fill_col_q <= colour_q;
        end
        S_FILL: begin
          if (step) begin
            if (cx_q < xh_q) begin
              cx_q <= cx_q + 8'd1;
            end else begin
              cx_q <= xl_q;
              cy_q <= cy_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// tb_fb_fill_ctrl: randomized bench for fb_fill_ctrl
// reference model expands each rectangle into its pixel list
module tb_fb_fill_ctrl;

  localparam logic [7:0] BASE = 8'hC0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  bus_addr;
  logic        bus_we;
  logic        tb_drv;
  logic [7:0]  tb_val;
  wire  [7:0]  bus_data;
  logic        pix_req;
  logic [14:0] pix_addr;
  logic        pix_data;
  logic        pix_gnt;
  logic [14:0] fb_addr;
  logic        fb_data;
  logic        fb_we;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign bus_data = tb_drv ? tb_val : 8'bz;

  always #5 clk = ~clk;

  fb_fill_ctrl dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .BUS_ADDR (bus_addr),
    .BUS_DATA (bus_data),
    .BUS_WE   (bus_we),
    .PIX_REQ  (pix_req),
    .PIX_ADDR (pix_addr),
    .PIX_DATA (pix_data),
    .PIX_GNT  (pix_gnt),
    .FB_ADDR  (fb_addr),
    .FB_DATA  (fb_data),
    .FB_WE    (fb_we),
    .BUSY     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_addr = 8'h00;
    bus_we   = 1'b0;
    tb_drv   = 1'b0;
    tb_val   = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] o, input logic [7:0] d);
    bus_addr = BASE + o;
    bus_we   = 1'b1;
    tb_drv   = 1'b1;
    tb_val   = d;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [7:0] o, output logic [7:0] d);
    bus_addr = BASE + o;
    bus_we   = 1'b0;
    tb_drv   = 1'b0;
    tick();
    bus_idle();
    #2;
    d = bus_data;
    tick();
  endtask

  // stall_mode: 0 none, 1 random, 2 fixed 3-cycle burst at 0x1234
  task automatic run_fill(
    input string      name,
    input logic [7:0] x0, input logic [7:0] y0,
    input logic [7:0] x1, input logic [7:0] y1,
    input logic       col,
    input int         stall_mode,
    input bit         tamper,
    input int         abort_k
  );
    logic [14:0] q[$];
    int xl, xh, yl, yh;
    int k, idle;
    bit aborted, busy_e, fill_ph, we_e;
    logic [14:0] addr_e;
    logic d_e;
    logic [7:0] st;

    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
    if (xl > 159) xl = 159;
    if (xh > 159) xh = 159;
    if (yl > 119) yl = 119;
    if (yh > 119) yh = 119;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        q.push_back(15'(y * 256 + x));

    bus_write(8'd0, x0);
    bus_write(8'd1, y0);
    bus_write(8'd2, x1);
    bus_write(8'd3, y1);
    bus_write(8'd4, {1'b1, 6'b0, col});

    k = 1;
    idle = 0;
    aborted = 0;
    while (idle < 3) begin
      bus_idle();
      pix_addr = 15'($urandom);
      pix_data = 1'($urandom);
      case (stall_mode)
        1: pix_req = ($urandom_range(3) == 0);
        2: begin
          pix_req  = (k >= 4 && k <= 6);
          pix_addr = 15'h1234;
          pix_data = 1'b1;
        end
        default: pix_req = 1'b0;
      endcase
      if (abort_k == k) begin
        bus_addr = BASE + 8'd4; bus_we = 1'b1;
        tb_drv = 1'b1; tb_val = 8'h40;
      end else if (tamper && k == 3) begin
        bus_addr = BASE + 8'd4; bus_we = 1'b1;
        tb_drv = 1'b1; tb_val = {7'b0, ~col};
      end else if (tamper && k == 4) begin
        bus_addr = BASE; bus_we = 1'b1;
        tb_drv = 1'b1; tb_val = 8'h55;
      end else if (tamper && k == 5) begin
        bus_addr = BASE + 8'd4; bus_we = 1'b1;
        tb_drv = 1'b1; tb_val = {1'b1, 6'b0, ~col};
      end
      #2;
      busy_e  = !aborted && q.size() > 0;
      fill_ph = busy_e && k >= 2;
      we_e = 1'b0; addr_e = 15'h0; d_e = 1'b0;
      if (pix_req) begin
        we_e = 1'b1; addr_e = pix_addr; d_e = pix_data;
      end else if (fill_ph) begin
        we_e = 1'b1; addr_e = q[0]; d_e = col;
      end

      total_cnt++;
      if (busy !== busy_e)
        $display("FAIL %s busy k=%0d got %b want %b",
                 name, k, busy, busy_e);
      else pass_cnt++;
      total_cnt++;
      if (fb_we !== we_e)
        $display("FAIL %s fb_we k=%0d got %b want %b",
                 name, k, fb_we, we_e);
      else pass_cnt++;
      total_cnt++;
      if (pix_gnt !== pix_req)
        $display("FAIL %s pix_gnt k=%0d got %b want %b",
                 name, k, pix_gnt, pix_req);
      else pass_cnt++;
      if (we_e) begin
        total_cnt++;
        if (fb_addr !== addr_e || fb_data !== d_e)
          $display("FAIL %s write k=%0d got %h/%b want %h/%b",
                   name, k, fb_addr, fb_data, addr_e, d_e);
        else pass_cnt++;
      end

      if (fill_ph && !pix_req) void'(q.pop_front());
      if (abort_k == k) aborted = 1;
      if (!busy_e) idle++;
      tick();
      k++;
      if (k > 5000) begin
        total_cnt++;
        $display("FAIL %s timeout left=%0d", name, q.size());
        break;
      end
    end
    pix_req = 1'b0;
    bus_idle();

    bus_read(8'd5, st);
    total_cnt++;
    if (st !== (aborted ? 8'h00 : 8'h02))
      $display("FAIL %s status got %h want %h",
               name, st, aborted ? 8'h00 : 8'h02);
    else pass_cnt++;
    bus_read(8'd5, st);
    total_cnt++;
    if (st !== 8'h00)
      $display("FAIL %s status_clr got %h want 00", name, st);
    else pass_cnt++;
    if (tamper) begin
      bus_read(8'd0, st);
      total_cnt++;
      if (st !== x0)
        $display("FAIL %s x0_locked got %h want %h", name, st, x0);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    bus_idle();
    pix_req = 1'b0; pix_addr = 15'h0; pix_data = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    total_cnt++;
    if (busy !== 1'b0 || fb_we !== 1'b0 ||
        fb_addr !== 15'h0 || fb_data !== 1'b0)
      $display("FAIL reset_out got %b %b %h %b want 0 0 0000 0",
               busy, fb_we, fb_addr, fb_data);
    else pass_cnt++;
    pix_req = 1'b1; pix_addr = 15'h5ABC; pix_data = 1'b1;
    #1;
    total_cnt++;
    if (pix_gnt !== 1'b1 || fb_we !== 1'b1 ||
        fb_addr !== 15'h5ABC || fb_data !== 1'b1)
      $display("FAIL reset_pix got %b %b %h %b want 1 1 5abc 1",
               pix_gnt, fb_we, fb_addr, fb_data);
    else pass_cnt++;
    pix_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus_read(8'(i), d);
      total_cnt++;
      if (d !== 8'h00)
        $display("FAIL reset_reg%0d got %h want 00", i, d);
      else pass_cnt++;
    end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    bus_write(8'd2, 8'hA5);
    bus_read(8'd2, d);
    total_cnt++;
    if (d !== 8'hA5) $display("FAIL reg_x1 got %h want a5", d);
    else pass_cnt++;
    bus_write(8'd4, 8'h41);
    bus_read(8'd4, d);
    total_cnt++;
    if (d !== 8'h01) $display("FAIL reg_ctrl got %h want 01", d);
    else pass_cnt++;
    bus_write(8'd5, 8'hFF);
    bus_read(8'd5, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL reg_status got %h want 00", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_midfill();
    logic [7:0] d;
    bus_write(8'd0, 8'd0);
    bus_write(8'd1, 8'd0);
    bus_write(8'd2, 8'd9);
    bus_write(8'd3, 8'd9);
    bus_write(8'd4, 8'h81);
    tick();
    tick();
    tick();
    total_cnt++;
    if (fb_we !== 1'b1 || busy !== 1'b1)
      $display("FAIL rst_mid_pre got %b %b want 1 1", fb_we, busy);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (fb_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid got %b %b want 0 0", fb_we, busy);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(8'd5, d);
    total_cnt++;
    if (d !== 8'h00) $display("FAIL rst_mid_status got %h want 00", d);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] xa, ya, xb, yb;
    for (int i = 0; i < 8; i++) begin
      xa = 8'($urandom_range(0, 170));
      ya = 8'($urandom_range(0, 125));
      xb = xa + 8'($urandom_range(0, 6));
      yb = ya + 8'($urandom_range(0, 4));
      if ($urandom_range(1)) run_fill("rand", xb, yb, xa, ya,
                                      1'($urandom), 1, 0, 0);
      else run_fill("rand", xa, ya, xb, yb, 1'($urandom), 1, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    run_fill("basic", 8'd2, 8'd3, 8'd4, 8'd4, 1'b1, 0, 1, 0);
    run_fill("swapped", 8'd10, 8'd0, 8'd8, 8'd0, 1'b1, 0, 0, 0);
    run_fill("clamp", 8'd158, 8'd118, 8'd200, 8'd130, 1'b0, 0, 0, 0);
    run_fill("single", 8'd77, 8'd66, 8'd77, 8'd66, 1'b1, 0, 0, 0);
    run_fill("stall", 8'd2, 8'd3, 8'd6, 8'd4, 1'b1, 2, 0, 0);
    run_fill("abort", 8'd0, 8'd0, 8'd9, 8'd9, 1'b1, 0, 0, 6);
    run_fill("restart", 8'd5, 8'd5, 8'd7, 8'd6, 1'b0, 0, 0, 0);
    run_fill("abort_setup", 8'd1, 8'd1, 8'd3, 8'd3, 1'b1, 0, 0, 1);
    test_reset_midfill();
    run_fill("post_rst", 8'd20, 8'd30, 8'd22, 8'd31, 1'b1, 1, 0, 0);
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
